mont_exp_ctrl: RTL

//  Initiator side of the montgomery start/done handshake. It computes x^e mod M by

---
 rtl/mont_exp_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl: computes x^e mod M by left-to-right square-and-multiply,
// driving an external Montgomery multiplier over a start/done handshake.
// Operands are moved into the Montgomery domain first (MM(x, R^2)) and
// moved back out at the end (MM(A, 1)).
module mont_exp_ctrl #(
   parameter int WIDTH   = 1024,
   parameter int E_WIDTH = 1024
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   in_x,
   input  logic [E_WIDTH-1:0] in_e,
   input  logic [WIDTH-1:0]   in_m,
   input  logic [WIDTH-1:0]   in_r,
   input  logic [WIDTH-1:0]   in_r2,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result,
   output logic               mul_start,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   output logic [WIDTH-1:0]   mul_m,
   input  logic [WIDTH:0]     mul_result,
   input  logic               mul_done
);

   localparam int IW = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_TOMONT_ISS,
      S_TOMONT_WAIT,
      S_SCAN,
      S_SQR_ISS,
      S_SQR_WAIT,
      S_MUL_ISS,
      S_MUL_WAIT,
      S_FROM_ISS,
      S_FROM_WAIT,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0]   x_q;
   logic [E_WIDTH-1:0] e_q;
   logic [WIDTH-1:0]   m_q;
   logic [WIDTH-1:0]   r2_q;
   logic [WIDTH-1:0]   xt_q;
   logic [WIDTH-1:0]   acc_q;
   logic [WIDTH-1:0]   result_q;
   logic [IW-1:0]      idx_q;

   logic [WIDTH-1:0]   prod;
   logic               bit_cur;
   logic               idx_zero;
   logic               unused_mul_msb;

   // The multiplier guarantees a fully reduced product, so its top bit carries no information.
   assign prod           = mul_result[WIDTH-1:0];
   assign unused_mul_msb = mul_result[WIDTH];
   assign bit_cur        = e_q[idx_q];
   assign idx_zero       = (idx_q == '0);

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; the NEXT step of the algorithm is folded into the SQR/MUL capture edge
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:        if (start) state_d = S_TOMONT_ISS;
         S_TOMONT_ISS:  state_d = S_TOMONT_WAIT;
         S_TOMONT_WAIT: if (mul_done) state_d = S_SCAN;
         S_SCAN: begin
            if (bit_cur)       state_d = S_SQR_ISS;
            else if (idx_zero) state_d = S_FROM_ISS;
         end
         S_SQR_ISS:     state_d = S_SQR_WAIT;
         S_SQR_WAIT: begin
            if (mul_done) begin
               if (bit_cur)       state_d = S_MUL_ISS;
               else if (idx_zero) state_d = S_FROM_ISS;
               else               state_d = S_SQR_ISS;
            end
         end
         S_MUL_ISS:     state_d = S_MUL_WAIT;
         S_MUL_WAIT: begin
            if (mul_done) begin
               if (idx_zero) state_d = S_FROM_ISS;
               else          state_d = S_SQR_ISS;
            end
         end
         S_FROM_ISS:    state_d = S_FROM_WAIT;
         S_FROM_WAIT:   if (mul_done) state_d = S_DONE;
         S_DONE:        state_d = S_IDLE;
         default:       state_d = S_IDLE;
      endcase
   end

   // Datapath registers: operand latch, bit index, accumulator and result capture
   always_ff @(posedge clk) begin
      if (reset) begin
         x_q      <= '0;
         e_q      <= '0;
         m_q      <= '0;
         r2_q     <= '0;
         xt_q     <= '0;
         acc_q    <= '0;
         result_q <= '0;
         idx_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  x_q   <= in_x;
                  e_q   <= in_e;
                  m_q   <= in_m;
                  r2_q  <= in_r2;
                  acc_q <= in_r;
                  idx_q <= IW'(E_WIDTH - 1);
               end
            end
            S_TOMONT_WAIT: if (mul_done) xt_q <= prod;
            S_SCAN: if (!bit_cur && !idx_zero) idx_q <= idx_q - 1'b1;
            S_SQR_WAIT: begin
               if (mul_done) begin
                  acc_q <= prod;
                  if (!bit_cur && !idx_zero) idx_q <= idx_q - 1'b1;
               end
            end
            S_MUL_WAIT: begin
               if (mul_done) begin
                  acc_q <= prod;
                  if (!idx_zero) idx_q <= idx_q - 1'b1;
               end
            end
            S_FROM_WAIT: if (mul_done) result_q <= prod;
            default: ;
         endcase
      end
   end

   // Outputs: operands are a pure function of state and registers that do not change while waiting
   always_comb begin
      busy      = 1'b1;
      done      = 1'b0;
      mul_start = 1'b0;
      mul_a     = '0;
      mul_b     = '0;
      case (state_q)
         S_IDLE: busy = 1'b0;
         S_DONE: begin
            busy = 1'b0;
            done = 1'b1;
         end
         S_TOMONT_ISS, S_TOMONT_WAIT: begin
            mul_start = (state_q == S_TOMONT_ISS);
            mul_a     = x_q;
            mul_b     = r2_q;
         end
         S_SQR_ISS, S_SQR_WAIT: begin
            mul_start = (state_q == S_SQR_ISS);
            mul_a     = acc_q;
            mul_b     = acc_q;
         end
         S_MUL_ISS, S_MUL_WAIT: begin
            mul_start = (state_q == S_MUL_ISS);
            mul_a     = acc_q;
            mul_b     = xt_q;
         end
         S_FROM_ISS, S_FROM_WAIT: begin
            mul_start = (state_q == S_FROM_ISS);
            mul_a     = acc_q;
            mul_b     = WIDTH'(1);
         end
         default: ;
      endcase
   end

   assign mul_m  = m_q;
   assign result = result_q;

endmodule
